// File: rtl/reg_bank_nbit.sv
// General-purpose register bank: one write port with load/inc/dec/clr,
// two combinational read ports, optional bypass and hard-wired zero R0.
module reg_bank_nbit #(
  parameter int WIDTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              wrap
);

  localparam int NUM_REGS = 2**ADDR_W;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic             wrap_q;
  logic             wrap_d;

  logic             wr_en;
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] nxt_val;
  logic             nxt_wrap;

  // Writes to a hard-wired R0 are dropped entirely, wrap included.
  assign wr_en = we &&
    !((ZERO_R0 != 0) && (waddr == '0));

  always_comb begin
    cur_val  = regs_q[waddr];
    nxt_val  = cur_val;
    nxt_wrap = 1'b0;
    unique case (op)
      OP_LOAD: nxt_val = wdata;
      OP_INC: begin
        nxt_val  = cur_val + 1'b1;
        nxt_wrap = &cur_val;
      end
      OP_DEC: begin
        nxt_val  = cur_val - 1'b1;
        nxt_wrap = ~|cur_val;
      end
      OP_CLR:  nxt_val = '0;
      default: nxt_val = cur_val;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    wrap_d = wrap_q;
    if (wr_en) begin
      regs_d[waddr] = nxt_val;
      wrap_d        = nxt_wrap;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end

  function automatic logic [WIDTH-1:0] rd_val(
    input logic [ADDR_W-1:0] a,
    input logic              wen,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  nv,
    input logic [WIDTH-1:0]  sv
  );
    logic [WIDTH-1:0] r;
    r = sv;
    if ((ZERO_R0 != 0) && (a == '0))
      r = '0;
    else if ((BYPASS != 0) && wen && (a == wa))
      r = nv;
    return r;
  endfunction

  always_comb begin
    rdata_a = rd_val(raddr_a, wr_en, waddr,
                     nxt_val, regs_q[raddr_a]);
    rdata_b = rd_val(raddr_b, wr_en, waddr,
                     nxt_val, regs_q[raddr_b]);
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_reg_bank_nbit.sv
// Directed bench for reg_bank_nbit: three parameter variants
// (bypass, no bypass, zero R0) share one stimulus stream.
module tb_reg_bank_nbit;

  logic       clk;
  logic       reset;
  logic       we;
  logic [1:0] op;
  logic [1:0] waddr;
  logic [3:0] wdata;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;

  logic [3:0] ra0, rb0, ra1, rb1, ra2, rb2;
  logic       wr0, wr1, wr2;

  int compared   = 0;
  int mismatched = 0;

  reg_bank_nbit #(.WIDTH(4), .ADDR_W(2),
    .BYPASS(1), .ZERO_R0(0)) u_byp (
    .clk(clk), .reset(reset), .we(we), .op(op),
    .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(ra0), .rdata_b(rb0), .wrap(wr0));

  reg_bank_nbit #(.WIDTH(4), .ADDR_W(2),
    .BYPASS(0), .ZERO_R0(0)) u_nbyp (
    .clk(clk), .reset(reset), .we(we), .op(op),
    .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(ra1), .rdata_b(rb1), .wrap(wr1));

  reg_bank_nbit #(.WIDTH(4), .ADDR_W(2),
    .BYPASS(1), .ZERO_R0(1)) u_zero (
    .clk(clk), .reset(reset), .we(we), .op(op),
    .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(ra2), .rdata_b(rb2), .wrap(wr2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] o,
                    input logic [1:0] a,
                    input logic [3:0] d);
    @(negedge clk);
    we    = 1'b1;
    op    = o;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a,
                    input logic [1:0] b);
    raddr_a = a;
    raddr_b = b;
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    we      = 1'b0;
    op      = 2'b00;
    waddr   = 2'd0;
    wdata   = 4'h0;
    raddr_a = 2'd0;
    raddr_b = 2'd0;
    #12;
    rd(2'd1, 2'd3);
    chk("rst_ra", ra0, 4'h0);
    chk("rst_rb", rb1, 4'h0);
    chk("rst_wrap", wr0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // 1: async reset pulse between edges
    wr(2'b00, 2'd1, 4'h5);
    wr(2'b00, 2'd2, 4'hA);
    wr(2'b00, 2'd3, 4'hF);
    rd(2'd3, 2'd2);
    chk("pre_r3", ra1, 4'hF);
    chk("pre_r2", rb1, 4'hA);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    rd(2'd1, 2'd2);
    chk("arst_r1", ra0, 4'h0);
    chk("arst_r2", rb1, 4'h0);
    rd(2'd3, 2'd3);
    chk("arst_r3", ra1, 4'h0);
    chk("arst_wrap", wr1, 1'b0);
    #1 reset = 1'b1;

    // 2: load and dual-port read
    wr(2'b00, 2'd1, 4'h3);
    wr(2'b00, 2'd2, 4'h9);
    rd(2'd2, 2'd2);
    chk("ld_ra", ra1, 4'h9);
    chk("ld_rb", rb1, 4'h9);
    chk("ld_ra_byp", ra0, 4'h9);
    rd(2'd1, 2'd3);
    chk("ld_r1", ra1, 4'h3);
    chk("ld_r3", rb1, 4'h0);

    // 3: wrap flag
    wr(2'b00, 2'd1, 4'hF);
    wr(2'b01, 2'd1, 4'h0);
    rd(2'd1, 2'd3);
    chk("inc_wrap_v", ra1, 4'h0);
    chk("inc_wrap_f", wr1, 1'b1);
    wr(2'b01, 2'd1, 4'h0);
    rd(2'd1, 2'd3);
    chk("inc_v", ra1, 4'h1);
    chk("inc_f", wr1, 1'b0);
    wr(2'b10, 2'd3, 4'h0);
    rd(2'd1, 2'd3);
    chk("dec_wrap_v", rb1, 4'hF);
    chk("dec_wrap_f", wr1, 1'b1);
    chk("dec_wrap_z", wr2, 1'b1);
    wr(2'b11, 2'd3, 4'h7);
    rd(2'd1, 2'd3);
    chk("clr_v", rb1, 4'h0);
    chk("clr_f", wr1, 1'b0);

    // 4: bypass vs stored value during a write
    wr(2'b00, 2'd0, 4'h3);
    @(negedge clk);
    we      = 1'b1;
    op      = 2'b01;
    waddr   = 2'd0;
    raddr_a = 2'd0;
    raddr_b = 2'd1;
    #1;
    chk("byp_a", ra0, 4'h4);
    chk("byp_b_other", rb0, 4'h1);
    chk("nbyp_a", ra1, 4'h3);
    chk("zero_a", ra2, 4'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    chk("nbyp_after", ra1, 4'h4);
    chk("byp_after", ra0, 4'h4);

    // 5: zero R0 discards write and keeps wrap
    wr(2'b10, 2'd3, 4'h0);
    chk("z_pre_wrap", wr2, 1'b1);
    wr(2'b00, 2'd0, 4'hC);
    rd(2'd0, 2'd0);
    chk("z_r0", ra2, 4'h0);
    chk("z_wrap", wr2, 1'b1);
    chk("nz_r0", rb0, 4'hC);
    chk("nz_wrap", wr0, 1'b0);

    // 6: idle hold with op/waddr driven
    @(negedge clk);
    we    = 1'b0;
    op    = 2'b11;
    waddr = 2'd1;
    repeat (10) @(posedge clk);
    #1;
    rd(2'd1, 2'd3);
    chk("hold_r1", ra2, 4'h1);
    chk("hold_wrap", wr2, 1'b1);
    chk("hold_r1_nb", ra1, 4'h1);
    chk("hold_r3", rb1, 4'hF);

    // reset held across an edge drops that write
    @(negedge clk);
    we    = 1'b1;
    op    = 2'b00;
    waddr = 2'd1;
    wdata = 4'h7;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd(2'd1, 2'd3);
    chk("rst_drop_r1", ra1, 4'h0);
    chk("rst_drop_wr", wr2, 1'b0);

    // write in the reset-release cycle executes
    wr(2'b10, 2'd2, 4'h0);
    rd(2'd2, 2'd2);
    chk("rel_dec_v", ra1, 4'hF);
    chk("rel_dec_f", wr1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
